// File: rtl/dma_desc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dma_desc_sequencer
// Brief    : Expands one tile transfer request into per-channel-plane DMA
//            descriptors, tracking read/write spatial positions across requests.
// Revision : 1.0
// ============================================================================
module dma_desc_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 10,
    parameter int TILE_W = 7,
    parameter int N_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        stream_i,
    input  logic [1:0]        layer_type_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [TILE_W-1:0] tile_D_i,
    input  logic [TILE_W-1:0] tile_K_i,
    input  logic [N_W-1:0]    tile_n_i,
    input  logic [DIM_W-1:0]  in_R_i,
    input  logic [DIM_W-1:0]  in_C_i,
    input  logic [DIM_W-1:0]  in_D_i,
    input  logic [DIM_W-1:0]  out_R_i,
    input  logic [DIM_W-1:0]  out_C_i,
    input  logic [DIM_W-1:0]  out_K_i,
    input  logic [TILE_W-1:0] d_idx_i,
    input  logic [TILE_W-1:0] k_idx_i,
    input  logic              pass_done_i,
    input  logic              desc_ready_i,
    input  logic              dma_done_i,
    output logic              desc_valid_o,
    output logic [ADDR_W-1:0] desc_addr_o,
    output logic [ADDR_W-1:0] desc_len_o,
    output logic              desc_write_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] c_st_filter = 3'd0;
    localparam logic [2:0] c_st_ifmap  = 3'd1;
    localparam logic [2:0] c_st_bias   = 3'd2;
    localparam logic [2:0] c_st_opsum  = 3'd3;
    localparam logic [2:0] c_st_ipsum  = 3'd4;
    localparam logic [2:0] c_st_ofmap  = 3'd5;
    localparam logic [1:0] c_ly_dw     = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_next_state;

    logic [2:0]        r_stream;
    logic [1:0]        r_layer;
    logic [ADDR_W-1:0] r_base;
    logic [TILE_W-1:0] r_tile_d, r_tile_k, r_d_idx, r_k_idx, r_ch;
    logic [N_W-1:0]    r_tile_n;
    logic [DIM_W-1:0]  r_in_r, r_in_c, r_in_d, r_out_r, r_out_c, r_out_k;
    logic [ADDR_W-1:0] r_rd_pos, r_wr_pos;
    logic              r_adv;
    logic              r_valid, r_write, r_done, r_err;
    logic [ADDR_W-1:0] r_addr, r_len;

    logic              w_is_in, w_is_fmap, w_use_rd, w_eb2, w_dw, w_is_write;
    logic [ADDR_W-1:0] w_rows, w_cols, w_tot_ch, w_tile_ch, w_idx;
    logic [ADDR_W-1:0] w_tile_d, w_tile_k, w_d_idx, w_k_idx, w_out_k;
    logic [ADDR_W-1:0] w_plane, w_ch_base, w_ch_left, w_n_ch, w_seg, w_pos, w_rem;
    logic [ADDR_W-1:0] w_fm_len, w_fm_off, w_off, w_len_el, w_addr, w_len_b;
    logic              w_empty, w_last, w_illegal, w_illegal_in;

    assign w_is_in    = (r_stream == c_st_ifmap);
    assign w_is_fmap  = w_is_in || (r_stream == c_st_opsum) || (r_stream == c_st_ipsum)
                        || (r_stream == c_st_ofmap);
    assign w_use_rd   = w_is_in || (r_stream == c_st_ipsum);
    assign w_eb2      = (r_stream == c_st_bias) || (r_stream == c_st_opsum)
                        || (r_stream == c_st_ipsum);
    assign w_is_write = (r_stream == c_st_opsum) || (r_stream == c_st_ofmap);
    assign w_dw       = (r_layer == c_ly_dw);

    assign w_rows    = ADDR_W'(w_is_in ? r_in_r : r_out_r);
    assign w_cols    = ADDR_W'(w_is_in ? r_in_c : r_out_c);
    assign w_tot_ch  = ADDR_W'(w_is_in ? r_in_d : r_out_k);
    assign w_tile_ch = ADDR_W'(w_is_in ? r_tile_d : r_tile_k);
    assign w_idx     = ADDR_W'(w_is_in ? r_d_idx : r_k_idx);
    assign w_tile_d  = ADDR_W'(r_tile_d);
    assign w_tile_k  = ADDR_W'(r_tile_k);
    assign w_d_idx   = ADDR_W'(r_d_idx);
    assign w_k_idx   = ADDR_W'(r_k_idx);
    assign w_out_k   = ADDR_W'(r_out_k);

    // Feature-map geometry: clamp the channel group and the segment at the map edges
    assign w_plane   = w_rows * w_cols;
    assign w_ch_base = w_idx * w_tile_ch;
    assign w_ch_left = w_tot_ch - w_ch_base;
    assign w_n_ch    = (w_ch_base >= w_tot_ch) ? '0
                     : ((w_tile_ch < w_ch_left) ? w_tile_ch : w_ch_left);
    assign w_seg     = w_dw ? ADDR_W'(r_tile_n) * w_cols : ADDR_W'(r_tile_n);
    assign w_pos     = w_use_rd ? r_rd_pos : r_wr_pos;
    assign w_rem     = w_plane - w_pos;
    assign w_fm_len  = (w_pos >= w_plane) ? '0 : ((w_seg < w_rem) ? w_seg : w_rem);
    assign w_fm_off  = (w_ch_base + ADDR_W'(r_ch)) * w_plane + w_pos;

    always_comb begin
        w_off    = '0;
        w_len_el = '0;
        case (r_stream)
            c_st_filter: begin
                if (w_dw) begin
                    w_off    = w_k_idx * w_tile_k * ADDR_W'(9);
                    w_len_el = w_tile_k * ADDR_W'(9);
                end else begin
                    w_off    = w_k_idx * w_tile_d * w_tile_k + w_d_idx * w_tile_d * w_out_k;
                    w_len_el = w_tile_d * w_tile_k;
                end
            end
            c_st_bias: begin
                w_off    = w_k_idx * w_tile_k;
                w_len_el = w_tile_k;
            end
            default: begin
                if (w_is_fmap) begin
                    w_off    = w_fm_off;
                    w_len_el = w_fm_len;
                end
            end
        endcase
    end

    assign w_empty      = (w_len_el == '0) || (w_is_fmap && (w_n_ch == '0));
    assign w_last       = !w_is_fmap || ((ADDR_W'(r_ch) + ADDR_W'(1)) >= w_n_ch);
    assign w_addr       = r_base + (w_eb2 ? (w_off << 1) : w_off);
    assign w_len_b      = w_eb2 ? (w_len_el << 1) : w_len_el;
    assign w_illegal    = (r_stream > c_st_ofmap) || (r_layer > c_ly_dw);
    assign w_illegal_in = (stream_i > c_st_ofmap) || (layer_type_i > c_ly_dw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next_state = w_illegal_in ? S_DONE : S_CALC;
            S_CALC:  w_next_state = w_empty ? S_DONE : S_ISSUE;
            S_ISSUE: if (r_valid && desc_ready_i) w_next_state = S_WAIT;
            S_WAIT:  if (dma_done_i) w_next_state = w_last ? S_DONE : S_CALC;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stream <= '0; r_layer  <= '0; r_base   <= '0;
            r_tile_d <= '0; r_tile_k <= '0; r_tile_n <= '0;
            r_in_r   <= '0; r_in_c   <= '0; r_in_d   <= '0;
            r_out_r  <= '0; r_out_c  <= '0; r_out_k  <= '0;
            r_d_idx  <= '0; r_k_idx  <= '0; r_ch     <= '0;
            r_adv    <= 1'b0;
            r_rd_pos <= '0; r_wr_pos <= '0;
            r_valid  <= 1'b0; r_write <= 1'b0;
            r_addr   <= '0; r_len    <= '0;
            r_done   <= 1'b0; r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_stream <= stream_i; r_layer  <= layer_type_i; r_base <= base_i;
                r_tile_d <= tile_D_i; r_tile_k <= tile_K_i;     r_tile_n <= tile_n_i;
                r_in_r   <= in_R_i;   r_in_c   <= in_C_i;       r_in_d <= in_D_i;
                r_out_r  <= out_R_i;  r_out_c  <= out_C_i;      r_out_k <= out_K_i;
                r_d_idx  <= d_idx_i;  r_k_idx  <= k_idx_i;
                r_ch     <= '0;
                r_adv    <= 1'b0;
            end
            if (r_state == S_WAIT && dma_done_i) begin
                if (w_last) r_adv <= w_is_fmap;
                else        r_ch  <= r_ch + TILE_W'(1);
            end
            if (r_state == S_CALC && !w_empty) begin
                r_addr  <= w_addr;
                r_len   <= w_len_b;
                r_write <= w_is_write;
            end
            // Valid rises one cycle into ISSUE and falls right after acceptance
            if (r_state == S_ISSUE) begin
                if (!r_valid)          r_valid <= 1'b1;
                else if (desc_ready_i) r_valid <= 1'b0;
            end
            r_done <= (r_state == S_DONE);
            r_err  <= (r_state == S_DONE) && w_illegal;
            if (pass_done_i) begin
                r_rd_pos <= '0;
                r_wr_pos <= '0;
            end else if (r_state == S_DONE && r_adv) begin
                if (w_use_rd) r_rd_pos <= r_rd_pos + w_seg;
                else          r_wr_pos <= r_wr_pos + w_seg;
            end
        end
    end

    assign desc_valid_o = r_valid;
    assign desc_addr_o  = r_addr;
    assign desc_len_o   = r_len;
    assign desc_write_o = r_write;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
`default_nettype wire
